// File: rtl/tex_dcr_sequencer_if.sv
// Host DCR write port, texture pipeline handshake and DCR register-file write port
// of the texture DCR sequencer. The sequencer takes the slave view; the host side
// (or a testbench) takes the master view.
interface tex_dcr_sequencer_if #(
    parameter int ADDR_BITS = 12,
    parameter int DATA_BITS = 32
);
    // Host DCR write request
    logic                 req_valid;
    logic [ADDR_BITS-1:0] req_addr;
    logic [DATA_BITS-1:0] req_data;
    logic                 req_ready;

    // Texture pipeline handshake
    logic                 tex_req_fire;
    logic                 tex_rsp_fire;
    logic                 tex_stall;

    // Replayed DCR write towards the register file
    logic                 dcr_valid;
    logic [ADDR_BITS-1:0] dcr_addr;
    logic [DATA_BITS-1:0] dcr_data;

    // Sequencer has work queued or in progress
    logic                 busy;

    modport master (
        output req_valid, req_addr, req_data, tex_req_fire, tex_rsp_fire,
        input  req_ready, tex_stall, dcr_valid, dcr_addr, dcr_data, busy
    );

    modport slave (
        input  req_valid, req_addr, req_data, tex_req_fire, tex_rsp_fire,
        output req_ready, tex_stall, dcr_valid, dcr_addr, dcr_data, busy
    );
endinterface

// File: rtl/tex_dcr_sequencer.sv
// Texture DCR write sequencer.
// Buffers host DCR writes in a small FIFO, stalls new texture requests while any
// write is queued, waits for in-flight texture requests to retire, then replays
// the queued writes to the DCR register file one per cycle in arrival order.
module tex_dcr_sequencer #(
    parameter string INSTANCE_ID = "",
    parameter int    ADDR_BITS   = 12,
    parameter int    DATA_BITS   = 32,
    parameter int    DEPTH       = 4,
    parameter int    MAX_PENDING = 16
) (
    input logic                clk,
    input logic                reset_n,
    tex_dcr_sequencer_if.slave bus
);
    localparam int PTR_BITS  = $clog2(DEPTH);
    localparam int CNT_BITS  = $clog2(DEPTH + 1);
    localparam int PEND_BITS = $clog2(MAX_PENDING + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_QUIESCE = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] data;
    } entry_t;

    // Registered state
    state_t               r_state;
    entry_t               r_mem [DEPTH];
    logic [PTR_BITS-1:0]  r_wr_ptr;
    logic [PTR_BITS-1:0]  r_rd_ptr;
    logic [CNT_BITS-1:0]  r_count;
    logic [PEND_BITS-1:0] r_pending;
    logic                 r_dcr_valid;
    logic [ADDR_BITS-1:0] r_dcr_addr;
    logic [DATA_BITS-1:0] r_dcr_data;

    // Derived signals
    logic   w_empty;
    logic   w_full;
    logic   w_push;
    logic   w_pop;
    logic   w_pending_zero;
    logic   w_stall;
    entry_t w_head;

    assign w_empty        = (r_count == '0);
    assign w_full         = (r_count == CNT_BITS'(DEPTH));
    assign w_push         = bus.req_valid && !w_full;
    assign w_pending_zero = (r_pending == '0);
    assign w_head         = r_mem[r_rd_ptr];

    // Texture state may only change with the texture pipeline empty, so new
    // requests are held off as soon as any write is queued and until the
    // sequencer is back in IDLE.
    assign w_stall = (r_state != S_IDLE) || !w_empty;

    // Pop the head whenever a DCR write is to be issued on the next cycle:
    // on the edge that enters DRAIN and on every DRAIN edge with data queued.
    always_comb begin
        // NOTE: default assignment first so every path drives w_pop; a path
        // that leaves it unassigned would infer a latch.
        w_pop = 1'b0;
        case (r_state)
            S_IDLE,
            S_QUIESCE: w_pop = !w_empty && w_pending_zero;
            S_DRAIN:   w_pop = !w_empty;
            default:   w_pop = 1'b0;
        endcase
    end

    // FIFO storage: slot contents are written on every accepted host write.
    // NOTE: the storage array has no reset; r_count alone marks which slots are
    // live, so stale contents are never observed and the array can map onto
    // plain RAM or reset-less flops.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{addr: bus.req_addr, data: bus.req_data};
        end
    end

    // FIFO pointers and occupancy; a reset discards everything queued.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state is assigned with <= so every register samples
        // the pre-edge values of the others, independent of statement order.
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_BITS'(1);
                2'b01:   r_count <= r_count - CNT_BITS'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Count of texture requests in flight; a request and a response in the
    // same cycle cancel out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
        end else begin
            case ({bus.tex_req_fire, bus.tex_rsp_fire})
                2'b10:   r_pending <= r_pending + PEND_BITS'(1);
                2'b01:   r_pending <= r_pending - PEND_BITS'(1);
                default: r_pending <= r_pending;
            endcase
        end
    end

    // Sequencer FSM with registered DCR write outputs. The write strobe and its
    // address/data are loaded from the FIFO head on the same edge that pops it,
    // so a write accepted with nothing in flight strobes two cycles later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_dcr_valid <= 1'b0;
            r_dcr_addr  <= '0;
            r_dcr_data  <= '0;
        end else begin
            r_dcr_valid <= w_pop;
            if (w_pop) begin
                r_dcr_addr <= w_head.addr;
                r_dcr_data <= w_head.data;
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_state <= w_pending_zero ? S_DRAIN : S_QUIESCE;
                    end
                end
                S_QUIESCE: begin
                    // Stall is up, so the in-flight count can only fall here.
                    if (w_pending_zero) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // A write pushed on the edge that popped the last entry is
                    // popped next edge, keeping the burst gap-free; only an
                    // empty FIFO ends the burst.
                    if (w_empty) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = !w_full;
    assign bus.tex_stall = w_stall;
    assign bus.busy      = w_stall;
    assign bus.dcr_valid = r_dcr_valid;
    assign bus.dcr_addr  = r_dcr_addr;
    assign bus.dcr_data  = r_dcr_data;

`ifndef SYNTHESIS
    // A response with nothing in flight means the pending count lost track.
    a_pending_underflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(bus.tex_rsp_fire && !bus.tex_req_fire && w_pending_zero))
        else $error("%s: tex_rsp_fire with no texture request pending", INSTANCE_ID);

    // The pending counter is sized for MAX_PENDING requests and must not wrap.
    a_pending_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(bus.tex_req_fire && !bus.tex_rsp_fire && (r_pending == PEND_BITS'(MAX_PENDING))))
        else $error("%s: tex_req_fire with MAX_PENDING requests already in flight", INSTANCE_ID);

    // The consumer must honour the stall in the same cycle it is raised.
    a_req_during_stall: assert property (@(posedge clk) disable iff (!reset_n)
        !(bus.tex_req_fire && w_stall))
        else $error("%s: tex_req_fire while tex_stall is asserted", INSTANCE_ID);
`endif

`ifdef DBG_TRACE_TEX
    // Debug trace of every replayed DCR write.
    always @(posedge clk) begin
        if (reset_n && r_dcr_valid) begin
            $display("[%s] dcr write addr=0x%0h data=0x%0h", INSTANCE_ID, r_dcr_addr, r_dcr_data);
        end
    end
`endif

endmodule

// File: tb/tb_tex_dcr_sequencer.sv
// Self-checking bench for tex_dcr_sequencer. Stimulus pushes the expected DCR
// write into a scoreboard queue when it is issued; a monitor pops and compares
// on every dcr_valid cycle. Timing checks are made directly by the stimulus.
module tb_tex_dcr_sequencer;
    localparam int ADDR_BITS = 12;
    localparam int DATA_BITS = 32;

    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] data;
    } wr_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    wr_t  exp_q[$];
    int   dcr_log[$];

    tex_dcr_sequencer_if #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) bus ();

    tex_dcr_sequencer #(
        .INSTANCE_ID ("tb"),
        .ADDR_BITS   (ADDR_BITS),
        .DATA_BITS   (DATA_BITS),
        .DEPTH       (4),
        .MAX_PENDING (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Scoreboard monitor: every DCR strobe must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (reset_n && bus.dcr_valid === 1'b1) begin
                dcr_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL dcr_unexpected: write addr=0x%0h data=0x%0h with none expected (cycle %0d)",
                             bus.dcr_addr, bus.dcr_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("dcr_addr", 64'(bus.dcr_addr), 64'(e.addr));
                    check("dcr_data", 64'(bus.dcr_data), 64'(e.data));
                end
            end
        end
    end

    // Present one host write for a single edge; it must be accepted.
    task automatic issue(input logic [ADDR_BITS-1:0] a, input logic [DATA_BITS-1:0] d);
        check("req_ready", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_data  = d;
        exp_q.push_back('{addr: a, data: d});
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic pulse_req(input int n);
        repeat (n) begin
            bus.tex_req_fire = 1'b1;
            @(negedge clk);
        end
        bus.tex_req_fire = 1'b0;
    endtask

    task automatic pulse_rsp(input int n);
        repeat (n) begin
            bus.tex_rsp_fire = 1'b1;
            @(negedge clk);
        end
        bus.tex_rsp_fire = 1'b0;
    endtask

    initial begin
        int base;
        bit accepted;

        bus.req_valid    = 1'b0;
        bus.req_addr     = '0;
        bus.req_data     = '0;
        bus.tex_req_fire = 1'b0;
        bus.tex_rsp_fire = 1'b0;

        // Reset values
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_tex_stall", 64'(bus.tex_stall), 64'd0);
        check("rst_dcr_valid", 64'(bus.dcr_valid), 64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_dcr_addr",  64'(bus.dcr_addr),  64'd0);
        check("rst_dcr_data",  64'(bus.dcr_data),  64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Idle write: accepted at edge N, strobes in cycle N+2 only,
        // stall high for cycles N+1 and N+2.
        base = dcr_log.size();
        issue(12'h010, 32'h0000_00A5);
        check("idle_stall_n1", 64'(bus.tex_stall), 64'd1);
        check("idle_busy_n1",  64'(bus.busy),      64'd1);
        check("idle_valid_n1", 64'(bus.dcr_valid), 64'd0);
        @(negedge clk);
        check("idle_valid_n2", 64'(bus.dcr_valid), 64'd1);
        check("idle_stall_n2", 64'(bus.tex_stall), 64'd1);
        @(negedge clk);
        check("idle_valid_n3", 64'(bus.dcr_valid), 64'd0);
        check("idle_stall_n3", 64'(bus.tex_stall), 64'd0);
        check("idle_busy_n3",  64'(bus.busy),      64'd0);
        check("idle_count",    64'(dcr_log.size() - base), 64'd1);

        // Quiesce: three requests in flight hold the write back until the
        // third response; the strobe follows one cycle after pending hits 0.
        pulse_req(3);
        base = dcr_log.size();
        issue(12'h020, 32'h1111_2222);
        repeat (4) begin
            check("quiesce_hold_valid", 64'(bus.dcr_valid), 64'd0);
            check("quiesce_hold_stall", 64'(bus.tex_stall), 64'd1);
            @(negedge clk);
        end
        pulse_rsp(3);
        check("quiesce_valid_p0", 64'(bus.dcr_valid), 64'd0);
        @(negedge clk);
        check("quiesce_valid_p1", 64'(bus.dcr_valid), 64'd1);
        @(negedge clk);
        check("quiesce_valid_p2", 64'(bus.dcr_valid), 64'd0);
        check("quiesce_stall_p2", 64'(bus.tex_stall), 64'd0);
        check("quiesce_count",    64'(dcr_log.size() - base), 64'd1);

        // Full / burst: four writes fill the FIFO behind two pending requests,
        // the fifth waits, then all five drain on consecutive cycles.
        pulse_req(2);
        base = dcr_log.size();
        issue(12'h100, 32'hD000_0001);
        issue(12'h101, 32'hD000_0002);
        issue(12'h102, 32'hD000_0003);
        issue(12'h103, 32'hD000_0004);
        check("full_req_ready", 64'(bus.req_ready), 64'd0);
        check("full_busy",      64'(bus.busy),      64'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = 12'h104;
        bus.req_data  = 32'hD000_0005;
        repeat (2) begin
            @(negedge clk);
            check("full_hold_ready", 64'(bus.req_ready), 64'd0);
            check("full_hold_valid", 64'(bus.dcr_valid), 64'd0);
        end
        pulse_rsp(2);
        accepted = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!accepted && bus.req_valid && bus.req_ready) begin
                exp_q.push_back('{addr: 12'h104, data: 32'hD000_0005});
                accepted = 1'b1;
                @(negedge clk);
                bus.req_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        bus.req_valid = 1'b0;
        check("burst_fifth_accepted", 64'(accepted), 64'd1);
        check("burst_count", 64'(dcr_log.size() - base), 64'd5);
        if (dcr_log.size() - base == 5) begin
            check("burst_contiguous", 64'(dcr_log[base + 4] - dcr_log[base]), 64'd4);
        end
        check("burst_stall_end", 64'(bus.tex_stall), 64'd0);

        // Simultaneous request and response leave pending at 1: the write
        // must quiesce, and exactly one response must release it.
        pulse_req(1);
        bus.tex_req_fire = 1'b1;
        bus.tex_rsp_fire = 1'b1;
        @(negedge clk);
        bus.tex_req_fire = 1'b0;
        bus.tex_rsp_fire = 1'b0;
        base = dcr_log.size();
        issue(12'h030, 32'h3333_0000);
        repeat (3) begin
            check("simul_hold_valid", 64'(bus.dcr_valid), 64'd0);
            @(negedge clk);
        end
        pulse_rsp(1);
        check("simul_valid_p0", 64'(bus.dcr_valid), 64'd0);
        @(negedge clk);
        check("simul_valid_p1", 64'(bus.dcr_valid), 64'd1);
        @(negedge clk);
        check("simul_count", 64'(dcr_log.size() - base), 64'd1);

        // Each write lands on the edge that pops the last queued entry:
        // the burst continues without a gap.
        base = dcr_log.size();
        issue(12'h040, 32'h4444_0001);
        issue(12'h041, 32'h4444_0002);
        issue(12'h042, 32'h4444_0003);
        repeat (4) @(negedge clk);
        check("chain_count", 64'(dcr_log.size() - base), 64'd3);
        if (dcr_log.size() - base == 3) begin
            check("chain_contiguous", 64'(dcr_log[base + 2] - dcr_log[base]), 64'd2);
        end
        check("chain_stall_end", 64'(bus.tex_stall), 64'd0);

        // Reset in the middle of DRAIN with three entries still queued.
        pulse_req(1);
        issue(12'h050, 32'h5555_0001);
        issue(12'h051, 32'h5555_0002);
        issue(12'h052, 32'h5555_0003);
        issue(12'h053, 32'h5555_0004);
        pulse_rsp(1);
        @(negedge clk);
        check("pre_reset_valid", 64'(bus.dcr_valid), 64'd1);
        check("pre_reset_busy",  64'(bus.busy),      64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("mid_rst_tex_stall", 64'(bus.tex_stall), 64'd0);
        check("mid_rst_dcr_valid", 64'(bus.dcr_valid), 64'd0);
        check("mid_rst_busy",      64'(bus.busy),      64'd0);
        check("mid_rst_dcr_addr",  64'(bus.dcr_addr),  64'd0);
        check("mid_rst_dcr_data",  64'(bus.dcr_data),  64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        base = dcr_log.size();
        repeat (6) begin
            check("post_rst_valid", 64'(bus.dcr_valid), 64'd0);
            @(negedge clk);
        end
        check("post_rst_count", 64'(dcr_log.size() - base), 64'd0);
        check("post_rst_busy",  64'(bus.busy), 64'd0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
